// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Holds the FSM state encoding, the byte-address field layout
// (tag [7:5], index [4:2], offset [1:0]) and the block width.
package dcache_pkg;

  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int BLOCK_W = 32;
  localparam int BYTE_W  = 8;

  localparam int OFF_LSB = 0;
  localparam int IDX_LSB = OFF_LSB + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  // Pick one byte out of a block; byte 0 lives in bits [7:0].
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [BLOCK_W-1:0] blk,
                                                 input logic [OFF_W-1:0] off);
    return blk[{off, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: valid, dirty, tag and data per line.
// Ports:
//   clk, rst_n          clock, asynchronous active-low clear of all lines
//   index/tag/offset    lookup address fields (from the CPU address)
//   hit, rd_byte        combinational tag compare and byte select
//   line_dirty          selected line is valid and dirty (needs write-back)
//   line_tag, line_data stored tag and data of the selected line
//   byte_we, wr_byte    byte write into the looked-up line; sets dirty
//   fill_*              full-block fill from memory; sets valid, clears dirty
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   index,
  input  logic [TAG_W-1:0]   tag,
  input  logic [OFF_W-1:0]   offset,
  output logic               hit,
  output logic [BYTE_W-1:0]  rd_byte,
  output logic               line_dirty,
  output logic [TAG_W-1:0]   line_tag,
  output logic [BLOCK_W-1:0] line_data,
  input  logic               byte_we,
  input  logic [BYTE_W-1:0]  wr_byte,
  input  logic               fill_en,
  input  logic [IDX_W-1:0]   fill_index,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_data
);

  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;
  logic [TAG_W-1:0]      tags [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data [NUM_BLOCKS];

  assign line_tag   = tags[index];
  assign line_data  = data[index];
  assign line_dirty = valid[index] & dirty[index];
  assign hit        = valid[index] && (tags[index] == tag);
  assign rd_byte    = byte_sel(data[index], offset);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else if (fill_en) begin
      valid[fill_index] <= 1'b1;
      dirty[fill_index] <= 1'b0;
      tags[fill_index]  <= fill_tag;
      data[fill_index]  <= fill_data;
    end else if (byte_we) begin
      data[index][{offset, 3'b000} +: BYTE_W] <= wr_byte;
      dirty[index] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back data cache between the CPU load/store port and
// word-wide main memory. Hits complete without stalling; misses stall the
// CPU through BUSYWAIT while the line is written back (if dirty) and refilled.
// Ports:
//   CLK, RESET         clock, asynchronous active-low reset
//   READ, WRITE        CPU load/store request (both high is taken as a store)
//   ADDRESS            byte address {tag, index, offset}
//   WRITEDATA/READDATA store byte / load byte
//   BUSYWAIT           stall to the CPU
//   MEM_*              registered block interface to main memory
//   dbg_state          current FSM state for observation
//
// Memory handshake: MEM_READ or MEM_WRITE is raised together with a stable
// MEM_ADDRESS/MEM_WRITEDATA and held until an edge samples MEM_BUSYWAIT low;
// the request drops in the following cycle. The two are never high together.
module dcache
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int MEM_WORDS  = 64
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         READ,
  input  logic                         WRITE,
  input  logic [7:0]                   ADDRESS,
  input  logic [7:0]                   WRITEDATA,
  output logic [7:0]                   READDATA,
  output logic                         BUSYWAIT,
  output logic                         MEM_READ,
  output logic                         MEM_WRITE,
  output logic [$clog2(MEM_WORDS)-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]           MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]           MEM_READDATA,
  input  logic                         MEM_BUSYWAIT,
  output state_t                       dbg_state
);

  localparam int MA_W = $clog2(MEM_WORDS);

  state_t             state, state_next;
  logic               request, hit, line_dirty, byte_we, fill_en;
  logic [BYTE_W-1:0]  rd_byte;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_data, fill_buf;
  logic [MA_W-1:0]    req_blk, mem_addr_d;
  logic [BLOCK_W-1:0] mem_wdata_d;
  logic               mem_read_d, mem_write_d, miss_start;

  assign request    = READ | WRITE;
  assign miss_start = (state == IDLE) && request && !hit;
  assign dbg_state  = state;

  // Outputs are forced quiet while reset is held so the CPU sees no stall.
  assign BUSYWAIT = RESET && request && !((state == IDLE) && hit);
  assign READDATA = (RESET && (state == IDLE) && request && hit) ? rd_byte : '0;

  dcache_array #(.NUM_BLOCKS(NUM_BLOCKS)) u_array (
    .clk        (CLK),
    .rst_n      (RESET),
    .index      (ADDRESS[IDX_LSB +: IDX_W]),
    .tag        (ADDRESS[TAG_LSB +: TAG_W]),
    .offset     (ADDRESS[OFF_LSB +: OFF_W]),
    .hit        (hit),
    .rd_byte    (rd_byte),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_data  (line_data),
    .byte_we    (byte_we),
    .wr_byte    (WRITEDATA),
    .fill_en    (fill_en),
    .fill_index (req_blk[IDX_W-1:0]),
    .fill_tag   (req_blk[MA_W-1:IDX_W]),
    .fill_data  (fill_buf)
  );

  // Memory-port values are computed for the state being entered and then
  // registered, so nothing on MEM_* depends combinationally on CPU inputs.
  always_comb begin
    state_next  = state;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = MEM_ADDRESS;
    mem_wdata_d = MEM_WRITEDATA;
    byte_we     = 1'b0;
    fill_en     = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          if (hit) begin
            byte_we = WRITE;
          end else if (line_dirty) begin
            state_next  = WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {line_tag, ADDRESS[IDX_LSB +: IDX_W]};
            mem_wdata_d = line_data;
          end else begin
            state_next = FETCH;
            mem_read_d = 1'b1;
            mem_addr_d = ADDRESS[IDX_LSB +: MA_W];
          end
        end
      end
      WRITEBACK: begin
        mem_write_d = 1'b1;
        if (!MEM_BUSYWAIT) begin
          state_next  = FETCH;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = req_blk;
        end
      end
      FETCH: begin
        mem_read_d = 1'b1;
        if (!MEM_BUSYWAIT) begin
          state_next = UPDATE;
          mem_read_d = 1'b0;
        end
      end
      UPDATE: begin
        fill_en    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // req_blk and fill_buf capture the missed block address and the returned
  // data, so the fill completes even if the CPU drops its request mid-miss.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      req_blk       <= '0;
      fill_buf      <= '0;
    end else begin
      state         <= state_next;
      MEM_READ      <= mem_read_d;
      MEM_WRITE     <= mem_write_d;
      MEM_ADDRESS   <= mem_addr_d;
      MEM_WRITEDATA <= mem_wdata_d;
      if (miss_start) req_blk <= ADDRESS[IDX_LSB +: MA_W];
      if ((state == FETCH) && !MEM_BUSYWAIT) fill_buf <= MEM_READDATA;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Testbench for dcache: behavioural main memory with a programmable busy
// length, table-driven hit vectors, and hand-written miss/reset sequences.
module tb_dcache;
  import dcache_pkg::*;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         READ = 1'b0;
  logic         WRITE = 1'b0;
  logic [7:0]   ADDRESS = 8'h00;
  logic [7:0]   WRITEDATA = 8'h00;
  logic [7:0]   READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [5:0]   MEM_ADDRESS;
  logic [31:0]  MEM_WRITEDATA;
  logic [31:0]  MEM_READDATA;
  logic         MEM_BUSYWAIT;
  state_t       dbg_state;

  dcache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- counters and scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];      // expected load bytes
  logic [38:0] mem_q[$];      // expected memory transactions {wr, addr, data}

  // ---------------- main memory model ----------------
  logic [31:0] mem [64];
  logic        mem_ready = 1'b0;
  int          busy = 5;      // cycles MEM_BUSYWAIT stays high per transaction
  int          cnt = 0;
  logic [38:0] obs_buf [64];  // completed transactions, in order
  int          obs_wr = 0;
  int          obs_rd = 0;
  int          both_cnt = 0;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt < busy);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= $urandom;
      mem[1]    <= 32'hDDCCBBAA;
      mem[9]    <= 32'h44332211;
      mem_ready <= 1'b1;
    end else begin
      if (MEM_READ && MEM_WRITE) both_cnt <= both_cnt + 1;
      if (MEM_READ || MEM_WRITE) begin
        if (MEM_BUSYWAIT) begin
          cnt <= cnt + 1;
        end else begin
          cnt <= 0;
          obs_buf[obs_wr] <= {MEM_WRITE, MEM_ADDRESS, MEM_WRITE ? MEM_WRITEDATA : 32'h0};
          obs_wr <= obs_wr + 1;
          if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
      end else begin
        cnt <= 0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Compare every completed memory transaction against the expected queue.
  task automatic drain_mem(input string name);
    while (obs_rd < obs_wr) begin
      if (mem_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_mem actual=%h expected=none", name, obs_buf[obs_rd]);
      end else begin
        check_eq({name, "_mem"}, obs_buf[obs_rd], mem_q.pop_front());
      end
      obs_rd++;
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge. Holds the request until BUSYWAIT is low
  // at a falling edge, checks stall length and load byte, then releases.
  task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] exp_rdata,
                            input int exp_stall, input string name);
    int stall;
    READ = rd;
    WRITE = wr;
    ADDRESS = addr;
    WRITEDATA = wdata;
    if (rd && !wr) exp_q.push_back(exp_rdata);
    stall = 0;
    @(negedge CLK);
    while (BUSYWAIT && stall < 200) begin
      stall++;
      @(negedge CLK);
    end
    check_eq({name, "_stall"}, stall, exp_stall);
    if (rd && !wr) check_eq({name, "_rdata"}, READDATA, exp_q.pop_front());
    @(posedge CLK);
    #1;
    READ = 1'b0;
    WRITE = 1'b0;
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         exp_stall;
  } vec_t;

  vec_t vecs [5];

  // ---------------- test ----------------
  initial begin
    logic [7:0]  e;
    logic [31:0] blk;
    int          n;

    vecs[0] = '{1'b1, 1'b0, 8'h06, 8'h00, 8'hCC, 0};
    vecs[1] = '{1'b0, 1'b1, 8'h05, 8'h55, 8'h00, 0};
    vecs[2] = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h55, 0};
    vecs[3] = '{1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, 0};
    vecs[4] = '{1'b1, 1'b0, 8'h07, 8'h00, 8'hDD, 0};

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_busywait", BUSYWAIT, 0);
    check_eq("rst_readdata", READDATA, 0);
    check_eq("rst_mem_read", MEM_READ, 0);
    check_eq("rst_mem_write", MEM_WRITE, 0);
    check_eq("rst_mem_address", MEM_ADDRESS, 0);
    check_eq("rst_mem_writedata", MEM_WRITEDATA, 0);
    check_eq("rst_state", dbg_state, IDLE);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // cold miss: fetch block 1 after 5 busy cycles (1 + 6 + 1 stall cycles)
    mem_q.push_back({1'b0, 6'h01, 32'h0});
    cpu_access(1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, 8, "cold_miss");
    drain_mem("cold_miss");

    // hits on the filled line, including a store that dirties it
    for (int i = 0; i < 5; i++)
      cpu_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_rdata, vecs[i].exp_stall, $sformatf("vec%0d", i));
    drain_mem("vecs");

    // dirty miss: write back block 1 then fetch block 9
    mem_q.push_back({1'b1, 6'h01, 32'hDDCC55AA});
    mem_q.push_back({1'b0, 6'h09, 32'h0});
    cpu_access(1'b1, 1'b0, 8'h24, 8'h00, 8'h11, 14, "dirty_miss");
    drain_mem("dirty_miss");

    // the written-back block comes back with the stored byte
    mem_q.push_back({1'b0, 6'h01, 32'h0});
    cpu_access(1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, 8, "refetch");
    cpu_access(1'b1, 1'b0, 8'h05, 8'h00, 8'h55, 0, "refetch_b1");
    drain_mem("refetch");

    // reset pulsed in the middle of a fetch
    READ = 1'b1;
    ADDRESS = 8'h44;
    n = 0;
    while (!MEM_READ && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check_eq("rstmid_fetch_started", MEM_READ, 1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    check_eq("rstmid_mem_read", MEM_READ, 0);
    check_eq("rstmid_busywait", BUSYWAIT, 0);
    check_eq("rstmid_state", dbg_state, IDLE);
    READ = 1'b0;
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    blk = mem[17];
    mem_q.push_back({1'b0, 6'h11, 32'h0});
    cpu_access(1'b1, 1'b0, 8'h44, 8'h00, blk[7:0], 8, "after_rst_miss");
    drain_mem("after_rst");

    // remaining tests use a random memory latency
    busy = $urandom_range(0, 3);

    // READ and WRITE together act as a store
    cpu_access(1'b1, 1'b1, 8'h44, 8'h77, 8'h00, 0, "rw_both");
    cpu_access(1'b1, 1'b0, 8'h44, 8'h00, 8'h77, 0, "rw_both_rd");
    cpu_access(1'b1, 1'b0, 8'h45, 8'h00, blk[15:8], 0, "rw_both_b1");

    // store miss allocates, then the byte write dirties the line
    blk = mem[26];
    mem_q.push_back({1'b0, 6'h1A, 32'h0});
    cpu_access(1'b0, 1'b1, 8'h68, 8'h9A, 8'h00, busy + 3, "store_miss");
    cpu_access(1'b1, 1'b0, 8'h68, 8'h00, 8'h9A, 0, "store_miss_rd");
    cpu_access(1'b1, 1'b0, 8'h6B, 8'h00, blk[31:24], 0, "store_miss_b3");
    drain_mem("store_miss");

    // evicting the store-allocated line writes the merged block back
    e = mem[18][7:0];
    mem_q.push_back({1'b1, 6'h1A, {blk[31:8], 8'h9A}});
    mem_q.push_back({1'b0, 6'h12, 32'h0});
    cpu_access(1'b1, 1'b0, 8'h48, 8'h00, e, 2 * busy + 4, "evict_store");
    drain_mem("evict_store");

    // request dropped mid-miss: the fill still completes
    e = mem[35][7:0];
    mem_q.push_back({1'b0, 6'h23, 32'h0});
    READ = 1'b1;
    ADDRESS = 8'h8C;
    n = 0;
    while (!MEM_READ && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check_eq("drop_fetch_started", MEM_READ, 1);
    @(posedge CLK);
    #1;
    READ = 1'b0;
    n = 0;
    @(negedge CLK);
    while ((dbg_state != IDLE || MEM_READ) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check_eq("drop_back_idle", dbg_state, IDLE);
    @(posedge CLK);
    #1;
    cpu_access(1'b1, 1'b0, 8'h8C, 8'h00, e, 0, "after_drop");
    drain_mem("after_drop");

    // final report
    check_eq("exp_q_empty", exp_q.size(), 0);
    check_eq("mem_q_empty", mem_q.size(), 0);
    check_eq("mem_rd_wr_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
